ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
- AHB-Lite slave that terminates one AHB_LITE_INTF slave port and drives a single-port synchronous SRAM macro with 1-cycle read latency.
- Sits directly downstream of the AHB-Lite interconnect/decoder.
- Handles address/data phase pipelining, byte lanes, wait states and the two-cycle ERROR response.

Parameters:
- ADDR_WIDTH, 32, AHB byte address width.
- DATA_WIDTH, 32, AHB/SRAM data width; 32 or 64.
- MEM_DEPTH, 1024, SRAM words; power of two.
- SRAM_AW, $clog2(MEM_DEPTH), derived SRAM word-address width; not to be overridden.

Ports:
- hclk  in  1  clock
- hreset  in  1  synchronous active-high reset
- hsel  in  1  slave select from decoder
- haddr  in  ADDR_WIDTH  byte address
- htrans  in  2  IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
- hsize  in  3  transfer size
- hwrite  in  1  1=write
- hwdata  in  DATA_WIDTH  write data (data phase)
- hready  in  1  bus-level ready (muxed)
- hrdata  out  DATA_WIDTH  read data
- hreadyout  out  1  slave ready
- hresp  out  1  0=OKAY 1=ERROR
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  SRAM write enable
- sram_be  out  DATA_WIDTH/8  byte enables
- sram_addr  out  SRAM_AW  word address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid cycle after read strobe

Behaviour:
- Clock and reset: single clock hclk. Reset hreset is synchronous and active-high.
- Reset values: state=IDLE, hreadyout=1, hresp=0, hrdata=0, sram_en=0, sram_we=0; captured address/be/write regs cleared.
- Address phase accepted on a rising edge when hsel & hready & htrans[1] & state in {IDLE, WRITE, READ2, ERR2}.
- On acceptance, capture:
  - word addr = haddr[SRAM_AW+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]; upper bits ignored (decoder owns the range).
  - byte enables from hsize and low haddr bits.
  - hwrite.
- IDLE/BUSY transfers, or hsel=0, are not accepted → next state IDLE, OKAY, zero wait.
- Error check at acceptance:
  - 8·2^hsize > DATA_WIDTH → error.
  - haddr not aligned to 2^hsize → error.
  - Error → ERR1.
- States:
  - IDLE: hreadyout=1, hresp=0.
  - WRITE: data phase. hreadyout=1. sram_en=1, sram_we=1, sram_be=captured be, sram_addr=captured, sram_wdata=hwdata (combinational). Zero wait.
  - READ1: hreadyout=0. sram_en=1, sram_we=0, sram_be=all 1s. Always → READ2.
  - READ2: hreadyout=1, hrdata=sram_rdata. Full word returned; master selects lanes.
  - ERR1: hreadyout=0, hresp=1. Always → ERR2.
  - ERR2: hreadyout=1, hresp=1.
- Transitions from ready states (IDLE, WRITE, READ2, ERR2):
  - Accepted write → WRITE.
  - Accepted read → READ1.
  - Accepted error → ERR1.
  - Otherwise → IDLE.
- hrdata=0 outside READ2. sram_en=0 outside WRITE/READ1.
- The SRAM port is used at most once per cycle. Back-to-back write→read is legal: read strobe issues the cycle after the write strobe.
- Address-phase inputs sampled during READ1/ERR1 are ignored; the master must hold them per AHB-Lite.
- Reset asserted mid-transfer: next cycle IDLE. Any in-flight read/write is dropped; no SRAM strobe in the cycle after reset.

Optional Feature:
- Macro: AHB_SRAM_PARITY_EN.
- Enabled:
  - sram_wdata and sram_rdata widen to DATA_WIDTH+DATA_WIDTH/8. The upper bits hold even parity per byte, computed from hwdata in WRITE.
  - In READ2, parity is checked on all bytes.
  - Any mismatch → READ2 replaced by ERR1→ERR2 sequencing. READ1 → ERRP (hreadyout=0, hresp=1, hrdata=0) → ERR2.
- Disabled: no parity bits, no parity logic, ports at DATA_WIDTH.

Decomposition:
- Package ahb_lite_pkg:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - hsize constants.
  - HRESP_OKAY/HRESP_ERROR.
  - slave state enum.
  - be_gen function (hsize, addr low bits → byte enables).
- Optional sub-module ahb_sram_parity (generate/check per byte), instantiated only under AHB_SRAM_PARITY_EN.

Test Plan:
- Word write 0xDEADBEEF @0x10, then read @0x10:
  - Write cycle: sram_we=1, be=4'b1111, addr=4.
  - Read: hreadyout 0 then 1, hrdata=0xDEADBEEF.
- Byte write 0xAA @0x13, hsize=0 → sram_be=4'b1000. Read word → 0xAAADBEEF.
- Back-to-back NONSEQ write@0x0 then read@0x0 → write strobe cycle N, read strobe N+1, data N+2, no lost transfer.
- Halfword @0x1 (unaligned) → hreadyout 0,1 with hresp 1,1, no sram_en. Next NONSEQ accepted in ERR2.
- hreset asserted during READ1 → next cycle hreadyout=1, hresp=0, sram_en=0, state IDLE.
- With AHB_SRAM_PARITY_EN, force a flipped parity bit on sram_rdata → ERROR two-cycle response, hrdata=0.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// AHB-Lite protocol constants, slave state encoding and byte-enable helper
// shared by the SRAM slave and its parity sub-block.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [2:0] slv_state_t;

    localparam slv_state_t ST_IDLE  = 3'd0;
    localparam slv_state_t ST_WRITE = 3'd1;
    localparam slv_state_t ST_READ1 = 3'd2;
    localparam slv_state_t ST_READ2 = 3'd3;
    localparam slv_state_t ST_ERR1  = 3'd4;
    localparam slv_state_t ST_ERR2  = 3'd5;

    // addr_lo is the byte offset within the bus word; callers take the low NB bits.
    function automatic logic [7:0] be_gen(input logic [2:0] hsize, input logic [2:0] addr_lo);
        logic [7:0] mask;
        case (hsize)
            HSIZE_BYTE: mask = 8'h01;
            HSIZE_HALF: mask = 8'h03;
            HSIZE_WORD: mask = 8'h0F;
            default:    mask = 8'hFF;
        endcase
        return mask << addr_lo;
    endfunction

endpackage

// File: rtl/ahb_sram_parity.sv
// Per-byte even parity generate/check for the SRAM data path.
// Only instantiated when AHB_SRAM_PARITY_EN is defined.
module ahb_sram_parity
    import ahb_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]              wdata,
    output logic [DATA_WIDTH/8-1:0]            wpar,
    input  logic [DATA_WIDTH+DATA_WIDTH/8-1:0] rdata,
    output logic                               rerr
);
    localparam int NB = DATA_WIDTH / 8;

    always_comb begin
        wpar = '0;
        rerr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            wpar[i] = ^wdata[8*i +: 8];
            rerr    = rerr | ((^rdata[8*i +: 8]) ^ rdata[DATA_WIDTH+i]);
        end
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave fronting a 1-cycle-latency single-port SRAM.
// Define AHB_SRAM_PARITY_EN to add per-byte even parity on the SRAM data path.
//
// state  | meaning
// IDLE   | no data phase pending, ready/OKAY
// WRITE  | write data phase, SRAM write strobe from live hwdata, zero wait
// READ1  | read strobe issued, one wait state
// READ2  | SRAM data returned on hrdata (parity fail: ERRP, hready low + ERROR)
// ERR1   | first ERROR cycle, hready low
// ERR2   | second ERROR cycle, hready high
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32,
    parameter int  MEM_DEPTH  = 1024,
    localparam int SRAM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic [ADDR_WIDTH-1:0]     haddr,
    input  logic [1:0]                htrans,
    input  logic [2:0]                hsize,
    input  logic                      hwrite,
    input  logic [DATA_WIDTH-1:0]     hwdata,
    input  logic                      hready,
    output logic [DATA_WIDTH-1:0]     hrdata,
    output logic                      hreadyout,
    output logic                      hresp,
    output logic                      sram_en,
    output logic                      sram_we,
    output logic [DATA_WIDTH/8-1:0]   sram_be,
    output logic [SRAM_AW-1:0]        sram_addr,
`ifdef AHB_SRAM_PARITY_EN
    output logic [DATA_WIDTH+DATA_WIDTH/8-1:0] sram_wdata,
    input  logic [DATA_WIDTH+DATA_WIDTH/8-1:0] sram_rdata
`else
    output logic [DATA_WIDTH-1:0]     sram_wdata,
    input  logic [DATA_WIDTH-1:0]     sram_rdata
`endif
);
    localparam int         NB       = DATA_WIDTH / 8;
    localparam int         BO       = $clog2(NB);
    localparam logic [2:0] MAX_SIZE = 3'(BO);

    slv_state_t         state_q, state_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [NB-1:0]      be_q, be_d;
    logic [2:0]         addr_lo;
    logic [7:0]         be_full;
    logic               size_err, misalign, ready_st, accept, par_err;
    logic               unused_ok;

    always_comb begin
        addr_lo         = '0;
        addr_lo[BO-1:0] = haddr[BO-1:0];
    end

    assign be_full  = be_gen(hsize, addr_lo);
    assign size_err = hsize > MAX_SIZE;

    always_comb begin
        case (hsize)
            HSIZE_BYTE:  misalign = 1'b0;
            HSIZE_HALF:  misalign = haddr[0];
            HSIZE_WORD:  misalign = |haddr[1:0];
            HSIZE_DWORD: misalign = |haddr[2:0];
            default:     misalign = 1'b1;
        endcase
    end

`ifdef AHB_SRAM_PARITY_EN
    logic [NB-1:0] wpar;
    logic          rerr;

    ahb_sram_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .wdata (hwdata),
        .wpar  (wpar),
        .rdata (sram_rdata),
        .rerr  (rerr)
    );

    assign par_err    = (state_q == ST_READ2) && rerr;
    assign sram_wdata = {wpar, hwdata};
`else
    assign par_err    = 1'b0;
    assign sram_wdata = hwdata;
`endif

    // A parity-failed READ2 behaves as a wait state, so it must not accept.
    assign ready_st = (state_q == ST_IDLE) || (state_q == ST_WRITE) || (state_q == ST_ERR2)
                   || ((state_q == ST_READ2) && !par_err);
    assign accept   = hsel && hready && htrans[1] && ready_st;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        case (state_q)
            ST_READ1: state_d = ST_READ2;
            ST_ERR1:  state_d = ST_ERR2;
            default: begin
                if (par_err) begin
                    state_d = ST_ERR2;
                end else if (accept) begin
                    addr_d = haddr[SRAM_AW+BO-1:BO];
                    be_d   = be_full[NB-1:0];
                    if (size_err || misalign) state_d = ST_ERR1;
                    else if (hwrite)          state_d = ST_WRITE;
                    else                      state_d = ST_READ1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        hrdata    = '0;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        sram_be   = '0;
        case (state_q)
            ST_WRITE: begin
                sram_en = 1'b1;
                sram_we = 1'b1;
                sram_be = be_q;
            end
            ST_READ1: begin
                hreadyout = 1'b0;
                sram_en   = 1'b1;
                sram_be   = '1;
            end
            ST_READ2: begin
                if (par_err) begin
                    hreadyout = 1'b0;
                    hresp     = HRESP_ERROR;
                end else begin
                    hrdata = sram_rdata[DATA_WIDTH-1:0];
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    assign sram_addr = addr_q;
    assign unused_ok = ^{haddr, htrans[0], be_full};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench for ahb_lite_sram_slave: byte-addressed reference memory,
// pipelined AHB driver and directed plus randomized transfer scenarios.
module tb_ahb_lite_sram_slave;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int DEPTH = 1024;
`ifdef AHB_SRAM_PARITY_EN
    localparam int SW = DW + NB;
`else
    localparam int SW = DW;
`endif

    logic          hclk = 1'b0;
    logic          hreset;
    logic          hsel;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic [2:0]    hsize;
    logic          hwrite;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic [DW-1:0] hrdata;
    logic          hreadyout;
    logic          hresp;
    logic          sram_en;
    logic          sram_we;
    logic [NB-1:0] sram_be;
    logic [9:0]    sram_addr;
    logic [SW-1:0] sram_wdata;
    logic [SW-1:0] sram_rdata;

    ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .hsel       (hsel),
        .haddr      (haddr),
        .htrans     (htrans),
        .hsize      (hsize),
        .hwrite     (hwrite),
        .hwdata     (hwdata),
        .hready     (hready),
        .hrdata     (hrdata),
        .hreadyout  (hreadyout),
        .hresp      (hresp),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 hclk = ~hclk;
    assign hready = hreadyout;

    // SRAM macro model, 1-cycle read latency
    logic [SW-1:0] mem [0:DEPTH-1];
    logic [SW-1:0] rd_q;
    logic [SW-1:0] flip_mask = '0;
    assign sram_rdata = rd_q ^ flip_mask;

    always @(posedge hclk) begin
        if (sram_en === 1'b1) begin
            if (sram_we === 1'b1) begin
                for (int l = 0; l < NB; l++) begin
                    if (sram_be[l]) begin
                        mem[sram_addr][8*l +: 8] = sram_wdata[8*l +: 8];
`ifdef AHB_SRAM_PARITY_EN
                        mem[sram_addr][DW+l] = sram_wdata[DW+l];
`endif
                    end
                end
            end else begin
                rd_q <= mem[sram_addr];
            end
        end
    end

    int         cyc = 0;
    int         wr_cyc = -1;
    int         rd_cyc = -1;
    logic [3:0] last_wr_be;
    logic [9:0] last_wr_addr;
    logic [31:0] last_rdata;

    always @(posedge hclk) cyc++;
    always @(negedge hclk) begin
        if (sram_en === 1'b1 && sram_we === 1'b1) begin
            wr_cyc       = cyc;
            last_wr_be   = sram_be;
            last_wr_addr = sram_addr;
        end
        if (sram_en === 1'b1 && sram_we === 1'b0) rd_cyc = cyc;
    end

    // Reference model: flat byte-addressed memory plus AHB response rules
    logic [7:0] ref_mem [0:4*DEPTH-1];

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        bit          write;
        logic [31:0] data;
        int          kind;   // 0 real transfer, 1 IDLE/BUSY, 2 hsel low
        logic [1:0]  trans;
    } xfer_t;

    xfer_t xq[$];
    int checks = 0;
    int errors = 0;

    function automatic bit is_err(xfer_t x);
        return (x.size > 3'd2) || ((x.addr & ((32'd1 << x.size) - 32'd1)) != 32'd0);
    endfunction

    function automatic int word_of(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [3:0] exp_be(xfer_t x);
        logic [3:0] be;
        int lo;
        be = '0;
        lo = int'(x.addr % 4);
        for (int b = 0; b < (1 << x.size); b++) if (lo + b < 4) be[lo + b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_word(logic [31:0] a);
        int w;
        w = word_of(a);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic model_write(xfer_t x);
        int lo;
        lo = int'(x.addr % 4);
        for (int b = 0; b < (1 << x.size); b++)
            ref_mem[4*word_of(x.addr) + lo + b] = x.data[8*(lo+b) +: 8];
    endtask

    function automatic void push(logic [31:0] a, logic [2:0] s, bit w, logic [31:0] d);
        xfer_t x;
        x.addr = a; x.size = s; x.write = w; x.data = d; x.kind = 0; x.trans = 2'b10;
        xq.push_back(x);
    endfunction

    task automatic init_mem();
        logic [31:0] v;
        for (int w = 0; w < DEPTH; w++) begin
            v = $urandom();
            mem[w] = '0;
            mem[w][31:0] = v;
            for (int l = 0; l < NB; l++) begin
                ref_mem[4*w+l] = v[8*l +: 8];
`ifdef AHB_SRAM_PARITY_EN
                mem[w][DW+l] = ^v[8*l +: 8];
`endif
            end
        end
    endtask

    // Pipelined driver: address phase of the queue head overlaps the data phase of the previous transfer.
    task automatic run_transfers();
        xfer_t       cur, dp;
        bit          dp_v, dp_err, exp_en, exp_we;
        int          waits, guard, limit;
        logic        rdy;
        logic [31:0] exp_rd;
        dp_v = 0; waits = 0; guard = 0;
        limit = 4 * xq.size() + 20;
        while ((xq.size() > 0 || dp_v) && guard < limit) begin
            if (xq.size() > 0) cur = xq[0];
            else begin
                cur.kind = 2; cur.trans = 2'b00; cur.addr = '0; cur.size = '0;
                cur.write = 0; cur.data = '0;
            end
            hsel   = (cur.kind != 2);
            htrans = cur.trans;
            haddr  = cur.addr;
            hsize  = cur.size;
            hwrite = cur.write;
            hwdata = dp_v ? dp.data : $urandom();
            @(negedge hclk);
            rdy = hreadyout;
            if (dp_v) begin
                dp_err = is_err(dp);
                exp_rd = (!dp.write && !dp_err && waits == 0) ? model_word(dp.addr) : '0;
                exp_en = !dp_err && (dp.write || waits > 0);
                exp_we = dp.write && !dp_err;
                checks++;
                if (hreadyout !== (waits == 0) || hresp !== dp_err) begin
                    errors++;
                    $display("FAIL resp addr=%h sz=%0d wr=%0b: rdy=%b resp=%b, want rdy=%b resp=%b",
                             dp.addr, dp.size, dp.write, hreadyout, hresp, waits == 0, dp_err);
                end
                checks++;
                if (hrdata !== exp_rd) begin
                    errors++;
                    $display("FAIL hrdata addr=%h: got %h want %h", dp.addr, hrdata, exp_rd);
                end
                checks++;
                if (sram_en !== exp_en || sram_we !== exp_we) begin
                    errors++;
                    $display("FAIL strobe addr=%h: en=%b we=%b want en=%b we=%b",
                             dp.addr, sram_en, sram_we, exp_en, exp_we);
                end
                if (exp_en) begin
                    checks++;
                    if (sram_addr !== 10'(word_of(dp.addr))
                        || (exp_we && (sram_be !== exp_be(dp) || sram_wdata[31:0] !== dp.data))
                        || (!exp_we && sram_be !== 4'hF)) begin
                        errors++;
                        $display("FAIL sram_port addr=%h: a=%h be=%b wd=%h want a=%h",
                                 dp.addr, sram_addr, sram_be, sram_wdata[31:0], 10'(word_of(dp.addr)));
                    end
                end
                if (rdy === 1'b1 && exp_we) model_write(dp);
                if (rdy === 1'b1 && !dp.write) last_rdata = hrdata;
            end else begin
                checks++;
                if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== '0 || sram_en !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_phase: rdy=%b resp=%b rdata=%h en=%b want 1 0 0 0",
                             hreadyout, hresp, hrdata, sram_en);
                end
            end
            @(posedge hclk); #1;
            guard++;
            if (rdy === 1'b1) begin
                dp_v = 0;
                if (xq.size() > 0) begin
                    void'(xq.pop_front());
                    if (cur.kind == 0) begin
                        dp = cur; dp_v = 1;
                        waits = (cur.write && !is_err(cur)) ? 0 : 1;
                    end
                end
            end else if (waits > 0) begin
                waits--;
            end
        end
        if (guard >= limit) begin
            checks++; errors++;
            $display("FAIL timeout: %0d cycles without draining, want < %0d", guard, limit);
            xq.delete();
        end
        hsel = 0; htrans = 2'b00;
    endtask

    task automatic test_reset();
        hreset = 1; hsel = 1; htrans = 2'b10; haddr = 32'h10; hsize = 3'd2; hwrite = 0; hwdata = '0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        checks++;
        if ({hreadyout, hresp} !== 2'b10) begin
            errors++; $display("FAIL reset_resp: rdy/resp=%b want 10", {hreadyout, hresp});
        end
        checks++;
        if (hrdata !== '0) begin errors++; $display("FAIL reset_hrdata: %h want 0", hrdata); end
        checks++;
        if ({sram_en, sram_we} !== 2'b00) begin
            errors++; $display("FAIL reset_sram: en/we=%b want 00", {sram_en, sram_we});
        end
        @(posedge hclk); #1;
        hreset = 0; hsel = 0; htrans = 2'b00;
    endtask

    task automatic test_word_write_read();
        push(32'h10, 3'd2, 1, 32'hDEADBEEF);
        xq.push_back('{addr: 32'h0, size: 3'd0, write: 0, data: 32'h0, kind: 1, trans: 2'b00});
        push(32'h10, 3'd2, 0, 32'h0);
        run_transfers();
        checks++;
        if (last_wr_addr !== 10'd4 || last_wr_be !== 4'b1111) begin
            errors++; $display("FAIL word_wr_port: addr=%0d be=%b want 4 1111", last_wr_addr, last_wr_be);
        end
        checks++;
        if (last_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_rd: got %h want deadbeef", last_rdata);
        end
    endtask

    task automatic test_byte_write();
        push(32'h13, 3'd0, 1, 32'hAA00_0000);
        push(32'h10, 3'd2, 0, 32'h0);
        run_transfers();
        checks++;
        if (last_wr_be !== 4'b1000) begin
            errors++; $display("FAIL byte_be: got %b want 1000", last_wr_be);
        end
        checks++;
        if (last_rdata !== 32'hAAADBEEF) begin
            errors++; $display("FAIL byte_rd: got %h want aaadbeef", last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        push(32'h0, 3'd2, 1, 32'h5A5A_C3C3);
        push(32'h0, 3'd2, 0, 32'h0);
        run_transfers();
        checks++;
        if (rd_cyc !== wr_cyc + 1) begin
            errors++; $display("FAIL b2b_timing: read strobe cyc %0d want %0d", rd_cyc, wr_cyc + 1);
        end
        checks++;
        if (last_rdata !== 32'h5A5A_C3C3) begin
            errors++; $display("FAIL b2b_data: got %h want 5a5ac3c3", last_rdata);
        end
    endtask

    task automatic test_unaligned_error();
        int wr_before;
        wr_before = wr_cyc;
        push(32'h1, 3'd1, 1, 32'hFFFF_FFFF);
        push(32'h10, 3'd2, 0, 32'h0);
        run_transfers();
        checks++;
        if (wr_cyc !== wr_before) begin
            errors++; $display("FAIL err_no_strobe: write strobe at cyc %0d want none", wr_cyc);
        end
        checks++;
        if (last_rdata !== 32'hAAADBEEF) begin
            errors++; $display("FAIL err_next_accept: got %h want aaadbeef", last_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        hsel = 1; htrans = 2'b10; haddr = 32'h10; hsize = 3'd2; hwrite = 0;
        @(posedge hclk); #1;
        @(negedge hclk);
        checks++;
        if (hreadyout !== 1'b0 || sram_en !== 1'b1) begin
            errors++; $display("FAIL rst_pre_read1: rdy=%b en=%b want 0 1", hreadyout, sram_en);
        end
        hreset = 1;
        @(posedge hclk); #1;
        hreset = 0; hsel = 0; htrans = 2'b00;
        @(negedge hclk);
        checks++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0 || sram_en !== 1'b0 || hrdata !== '0) begin
            errors++;
            $display("FAIL rst_mid_read: rdy=%b resp=%b en=%b rdata=%h want 1 0 0 0",
                     hreadyout, hresp, sram_en, hrdata);
        end
        @(posedge hclk); #1;
    endtask

    task automatic test_random();
        xfer_t x;
        int r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            x.addr  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
            x.write = bit'($urandom_range(0, 1));
            x.data  = $urandom();
            if (r < 10) begin
                x.kind = 1; x.trans = 2'($urandom_range(0, 1));
            end else if (r < 15) begin
                x.kind = 2; x.trans = 2'($urandom_range(2, 3));
            end else begin
                x.kind = 0; x.trans = 2'($urandom_range(2, 3));
            end
            xq.push_back(x);
        end
        run_transfers();
    endtask

`ifdef AHB_SRAM_PARITY_EN
    task automatic test_parity();
        push(32'h40, 3'd2, 1, 32'h0F0F_1234);
        run_transfers();
        flip_mask = '0;
        flip_mask[DW] = 1'b1;
        hsel = 1; htrans = 2'b10; haddr = 32'h40; hsize = 3'd2; hwrite = 0;
        @(posedge hclk); #1;
        hsel = 0; htrans = 2'b00;
        @(negedge hclk);
        checks++;
        if ({hreadyout, hresp} !== 2'b00) begin
            errors++; $display("FAIL par_read1: rdy/resp=%b want 00", {hreadyout, hresp});
        end
        @(posedge hclk); #1;
        @(negedge hclk);
        checks++;
        if ({hreadyout, hresp} !== 2'b01 || hrdata !== '0) begin
            errors++; $display("FAIL par_errp: rdy/resp=%b rdata=%h want 01 0", {hreadyout, hresp}, hrdata);
        end
        @(posedge hclk); #1;
        @(negedge hclk);
        checks++;
        if ({hreadyout, hresp} !== 2'b11) begin
            errors++; $display("FAIL par_err2: rdy/resp=%b want 11", {hreadyout, hresp});
        end
        @(posedge hclk); #1;
        flip_mask = '0;
        push(32'h40, 3'd2, 0, 32'h0);
        run_transfers();
        checks++;
        if (last_rdata !== 32'h0F0F_1234) begin
            errors++; $display("FAIL par_clean_rd: got %h want 0f0f1234", last_rdata);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        init_mem();
        test_reset();
        test_word_write_read();
        test_byte_write();
        test_back_to_back();
        test_unaligned_error();
        test_reset_mid_read();
        test_random();
`ifdef AHB_SRAM_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
